dft_seq_ctrl: RTL

DFT_SEQ_CTRL -- requirements
Module: dft_seq_ctrl

---
 rtl/dft_seq_pkg.sv | 22 ++
 rtl/dft_seq_buf.sv | 35 +++
 rtl/dft_seq_ctrl.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/dft_seq_pkg.sv
// Shared types and sizing for the DFT sequencer: state encoding and buffer geometry.
package dft_seq_pkg;

  localparam int NUM_WORDS        = 32;
  localparam int SAMPLE_W         = 16;
  localparam int WORD_W           = 64;
  localparam int SAMPLES_PER_WORD = WORD_W / SAMPLE_W;
  localparam int ADDR_W           = $clog2(NUM_WORDS);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_CAPTURE,
    ST_ERR
  } state_e;

  function automatic logic is_busy(input state_e st);
    return (st == ST_LOAD) || (st == ST_WAIT) || (st == ST_CAPTURE);
  endfunction

endpackage

// File: rtl/dft_seq_buf.sv
// 32x64 sample buffer: one write port and one registered read port (1-cycle latency).
// The read register clears on reset; the array contents do not.
module dft_seq_buf
  import dft_seq_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [WORD_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [WORD_W-1:0] rdata_o
);

  logic [WORD_W-1:0] mem_q [NUM_WORDS];
  logic [WORD_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read-before-write: a same-cycle write is visible on the following read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dft_seq_ctrl.sv
// Job sequencer around a streaming DFT core: streams the input buffer out, waits for the
// result strobe, captures the result stream. Optional WAIT timeout with DFT_SEQ_TIMEOUT_EN.
module dft_seq_ctrl
  import dft_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  input  logic              xwr_en_i,
  input  logic [ADDR_W-1:0] xwr_addr_i,
  input  logic [WORD_W-1:0] xwr_data_i,
  input  logic [ADDR_W-1:0] yrd_addr_i,
  output logic [WORD_W-1:0] yrd_data_o,
  output logic              dft_next_o,
  output logic [WORD_W-1:0] dft_x_o,
  input  logic              dft_next_out_i,
  input  logic [WORD_W-1:0] dft_y_i
);

  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(NUM_WORDS - 1);

  state_e            state_q;
  logic [ADDR_W-1:0] cnt_q;
  logic              busy_q;
  logic              done_q;
  logic              dft_next_q;
  logic [WORD_W-1:0] dft_x_q;

  logic              in_we;
  logic [ADDR_W-1:0] in_raddr;
  logic [WORD_W-1:0] in_rdata;
  logic              out_we;

`ifdef DFT_SEQ_TIMEOUT_EN
  localparam int WAIT_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_CNT_W-1:0] WAIT_LIMIT = WAIT_CNT_W'(TIMEOUT_CYCLES);
  logic [WAIT_CNT_W-1:0] wait_cnt_q;
  logic                  err_q;
`else
  // Referenced only so the parameter is not dangling when the timeout is compiled out.
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
`endif

  // Input writes are dropped while a job owns the buffer.
  assign in_we  = xwr_en_i && !busy_q && !rst_i;
  assign out_we = (state_q == ST_CAPTURE) && !rst_i;

  // Read-ahead: word 0 is fetched on the start edge, word 1 during the strobe cycle,
  // and afterwards two words ahead of the word currently on dft_x_o.
  always_comb begin
    in_raddr = '0;
    if (state_q == ST_LOAD) begin
      if (dft_next_q) begin
        in_raddr = ADDR_W'(1);
      end else begin
        in_raddr = cnt_q + ADDR_W'(2);
      end
    end
  end

  dft_seq_buf u_in_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (in_we),
    .waddr_i (xwr_addr_i),
    .wdata_i (xwr_data_i),
    .raddr_i (in_raddr),
    .rdata_o (in_rdata)
  );

  dft_seq_buf u_out_buf (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .we_i    (out_we),
    .waddr_i (cnt_q),
    .wdata_i (dft_y_i),
    .raddr_i (yrd_addr_i),
    .rdata_o (yrd_data_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      dft_next_q <= 1'b0;
      dft_x_q    <= '0;
`ifdef DFT_SEQ_TIMEOUT_EN
      wait_cnt_q <= '0;
      err_q      <= 1'b0;
`endif
    end else begin
      dft_next_q <= 1'b0;
      dft_x_q    <= '0;
      case (state_q)
        ST_IDLE, ST_ERR: begin
          if (start_i) begin
            state_q    <= ST_LOAD;
            busy_q     <= 1'b1;
            done_q     <= 1'b0;
            dft_next_q <= 1'b1;
            cnt_q      <= '0;
`ifdef DFT_SEQ_TIMEOUT_EN
            err_q      <= 1'b0;
`endif
          end
        end
        ST_LOAD: begin
          // cnt_q is the index of the word on dft_x_o; it holds at 0 during the strobe cycle.
          if (dft_next_q) begin
            dft_x_q <= in_rdata;
          end else if (cnt_q == CNT_LAST) begin
            state_q <= ST_WAIT;
            cnt_q   <= '0;
`ifdef DFT_SEQ_TIMEOUT_EN
            wait_cnt_q <= '0;
`endif
          end else begin
            dft_x_q <= in_rdata;
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        ST_WAIT: begin
          if (dft_next_out_i) begin
            state_q <= ST_CAPTURE;
            cnt_q   <= '0;
          end
`ifdef DFT_SEQ_TIMEOUT_EN
          else if (wait_cnt_q == WAIT_LIMIT) begin
            state_q <= ST_ERR;
            busy_q  <= 1'b0;
            err_q   <= 1'b1;
          end else begin
            wait_cnt_q <= wait_cnt_q + 1'b1;
          end
`endif
        end
        ST_CAPTURE: begin
          if (cnt_q == CNT_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cnt_q   <= '0;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign dft_next_o = dft_next_q;
  assign dft_x_o    = dft_x_q;

`ifdef DFT_SEQ_TIMEOUT_EN
  assign err_o = err_q;
`else
  assign err_o = 1'b0;
`endif

endmodule
